// File: rtl/unsigned_div_16by8_seq.sv
// Sequential restoring divider: 2*WIDTH-bit dividend / WIDTH-bit divisor, one quotient bit per cycle.
// Optional UDIV_FAST_ZERO_EN: dividend < divisor completes without iterating.
module unsigned_div_16by8_seq #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2*WIDTH-1:0]   dividend,
    input  logic [WIDTH-1:0]     divisor,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   quotient,
    output logic [WIDTH-1:0]     remainder,
    output logic                 div_zero
);

    localparam int CNT_W = $clog2(2*WIDTH);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t               state, state_nxt;
    logic [CNT_W-1:0]     cnt;
    logic [WIDTH-1:0]     rem;
    logic [WIDTH-1:0]     dvs;
    logic [2*WIDTH-1:0]   work;
    logic [WIDTH-1:0]     rem_step;
    logic [2*WIDTH-1:0]   work_step;
    logic                 q_bit;
    logic                 last_step;
    logic                 zero_div;
    logic                 fast_zero;

    // Shift in one dividend bit and compare on WIDTH+1 bits so the top bit is never lost.
    function automatic logic [WIDTH:0] restore_step(input logic [WIDTH-1:0] r,
                                                    input logic b,
                                                    input logic [WIDTH-1:0] d);
        logic [WIDTH:0]   sh;
        logic [WIDTH-1:0] diff;
        sh   = {r, b};
        diff = WIDTH'(sh - {1'b0, d});
        if (sh >= {1'b0, d})
            return {1'b1, diff};
        else
            return {1'b0, sh[WIDTH-1:0]};
    endfunction

    assign zero_div  = (divisor == '0);
    assign last_step = (cnt == CNT_W'(2*WIDTH-1));

`ifdef UDIV_FAST_ZERO_EN
    assign fast_zero = !zero_div && (dividend < {{WIDTH{1'b0}}, divisor});
`else
    assign fast_zero = 1'b0;
`endif

    // work holds the unconsumed dividend bits on top and collects quotient bits at the bottom.
    always_comb begin
        {q_bit, rem_step} = restore_step(rem, work[2*WIDTH-1], dvs);
        work_step         = {work[2*WIDTH-2:0], q_bit};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid)
                    state_nxt = (zero_div || fast_zero) ? DONE : CALC;
            end
            CALC: begin
                if (last_step)
                    state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            rem       <= '0;
            dvs       <= '0;
            work      <= '0;
            quotient  <= '0;
            remainder <= '0;
            div_zero  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        dvs  <= divisor;
                        work <= dividend;
                        rem  <= '0;
                        cnt  <= '0;
                        if (zero_div) begin
                            quotient  <= '1;
                            remainder <= dividend[WIDTH-1:0];
                            div_zero  <= 1'b1;
                        end else if (fast_zero) begin
                            quotient  <= '0;
                            remainder <= dividend[WIDTH-1:0];
                            div_zero  <= 1'b0;
                        end
                    end
                end
                CALC: begin
                    rem  <= rem_step;
                    work <= work_step;
                    cnt  <= last_step ? '0 : cnt + 1'b1;
                    if (last_step) begin
                        quotient  <= work_step;
                        remainder <= rem_step;
                        div_zero  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_unsigned_div_16by8_seq.sv
// Self-checking bench for unsigned_div_16by8_seq: directed cases plus random operands
// checked against plain-arithmetic division.
module tb_unsigned_div_16by8_seq;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] dividend;
    logic [7:0]  divisor;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] quotient;
    logic [7:0]  remainder;
    logic        div_zero;

    int checks = 0;
    int errors = 0;

    unsigned_div_16by8_seq #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dividend  (dividend),
        .divisor   (divisor),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (div_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one operation, check latency and results, hold for 'hold' cycles, then pop.
    task automatic do_op(input logic [15:0] z, input logic [7:0] y, input int hold);
        logic [15:0] eq;
        logic [7:0]  er;
        logic        ez;
        int          elat;
        int          lat;
        ez   = (y == 8'd0);
        eq   = ez ? 16'hFFFF : z / {8'd0, y};
        er   = ez ? z[7:0] : 8'(z % {8'd0, y});
        elat = ez ? 1 : 17;
`ifdef UDIV_FAST_ZERO_EN
        if (!ez && z < {8'd0, y}) elat = 1;
`endif
        @(negedge clk);
        chk("in_ready_idle", in_ready, 1);
        in_valid = 1'b1;
        dividend = z;
        divisor  = y;
        @(posedge clk); #1;
        in_valid = 1'b0;
        dividend = 16'($urandom);
        divisor  = 8'($urandom);
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("latency", lat, elat);
        chk("quotient", quotient, eq);
        chk("remainder", remainder, er);
        chk("div_zero", div_zero, ez);
        chk("in_ready_busy", in_ready, 0);
        repeat (hold) begin
            @(posedge clk); #1;
            chk("hold_valid", out_valid, 1);
            chk("hold_q", quotient, eq);
            chk("hold_r", remainder, er);
            chk("hold_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("pop_valid", out_valid, 0);
        chk("pop_in_ready", in_ready, 1);
    endtask

    initial begin
        logic [7:0] x;
        logic [7:0] y;
        rst_n     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        dividend  = '0;
        divisor   = '0;
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_q", quotient, 0);
        chk("rst_r", remainder, 0);
        chk("rst_dz", div_zero, 0);
        @(negedge clk) rst_n = 1'b1;

        do_op(16'hFFFF, 8'hFF, 0);
        chk("ffff_ff_q", quotient, 16'h0101);
        do_op(16'd1000, 8'd7, 1);
        chk("1000_7_q", quotient, 142);
        chk("1000_7_r", remainder, 6);
        do_op(16'h1234, 8'd0, 0);
        do_op(16'd255, 8'd16, 10);
        chk("255_16_q", quotient, 15);
        chk("255_16_r", remainder, 15);

        // Abort a calculation partway through with an asynchronous reset.
        @(negedge clk);
        in_valid = 1'b1;
        dividend = 16'd1000;
        divisor  = 8'd3;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("abort_out_valid", out_valid, 0);
        chk("abort_q", quotient, 0);
        chk("abort_in_ready", in_ready, 1);
        @(negedge clk) rst_n = 1'b1;
        do_op(16'd81, 8'd9, 0);
        chk("81_9_q", quotient, 9);
        chk("81_9_r", remainder, 0);

        do_op(16'd5, 8'd9, 0);
        do_op(16'd0, 8'd0, 0);
        do_op(16'd0, 8'd1, 0);
        do_op(16'd254, 8'd255, 1);

        // Products of 8-bit operands must divide back exactly.
        for (int i = 0; i < 120; i++) begin
            x = 8'($urandom);
            y = 8'($urandom_range(1, 255));
            do_op({8'd0, x} * {8'd0, y}, y, int'($urandom_range(0, 2)));
            chk("recon_x", quotient, {8'd0, x});
            chk("recon_rem", remainder, 0);
        end
        for (int i = 0; i < 60; i++) begin
            y = (i % 10 == 0) ? 8'd0 : 8'($urandom);
            do_op(16'($urandom), y, int'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
